// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types and constants used by the fetch stage
// (instruction_fetch, fetch_fifo) and its testbench.
package riscv_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;

    // Instruction addresses are word aligned; the low two bits are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: control from EX/ID, the instruction-memory port and the
// IF/ID output. master = fetch unit, slave = surrounding pipeline/memory.
interface instruction_fetch_if;
    import riscv_pkg::*;

    logic            stall;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [ILEN-1:0] imem_rdata;
    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic [ILEN-1:0] if_inst;

    modport master (
        input  stall, redirect, redirect_pc, imem_rdata,
        output imem_req, imem_addr, if_valid, if_pc, if_inst
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_rdata,
        input  imem_req, imem_addr, if_valid, if_pc, if_inst
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, inst} fetch entries with occupancy count and a
// registered head; flush (and reset) take priority over push.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output logic [CW-1:0] count,
    output fetch_entry_t head,
    output logic         empty
);

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    fetch_entry_t    mem_r [DEPTH];
    logic [PW-1:0]   rd_ptr_r;
    logic [PW-1:0]   wr_ptr_r;
    logic [CW-1:0]   count_r;
    logic            pop_ok_s;
    logic            push_ok_s;

    // Qualify requests against occupancy so the pointers can never cross.
    always_comb begin
        pop_ok_s  = 1'b0;
        push_ok_s = 1'b0;
        if (count_r != {CW{1'b0}}) begin
            pop_ok_s = pop;
        end else begin
            pop_ok_s = 1'b0;
        end
        if ((count_r != FULL_COUNT) || pop_ok_s) begin
            push_ok_s = push;
        end else begin
            push_ok_s = 1'b0;
        end
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; data needs no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok_s && !flush && !reset) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign empty = (count_r == {CW{1'b0}});

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC generation, 1-cycle imem requests under a credit rule, and
// a small FIFO toward IF/ID. Optional macro FETCH_BYPASS_EN adds an empty-FIFO bypass.
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 64'h0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    instruction_fetch_if.master bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int OW = CW + 1;

    logic [XLEN-1:0] fetch_pc_r;
    logic            inflight_r;
    logic [XLEN-1:0] inflight_pc_r;

    logic [CW-1:0]   fifo_count_s;
    fetch_entry_t    fifo_head_s;
    logic            fifo_empty_s;
    fetch_entry_t    push_data_s;

    logic            resp_valid_s;
    logic            push_s;
    logic            pop_s;
    logic            fifo_pop_s;
    logic            req_s;
    logic [OW-1:0]   occupancy_s;
    logic            valid_s;
    logic [XLEN-1:0] pc_s;
    logic [ILEN-1:0] inst_s;

    // Head selection toward IF/ID; NOP and PC 0 whenever nothing is valid.
    always_comb begin
        resp_valid_s = inflight_r && !bus.redirect && !reset;
        valid_s      = 1'b0;
        pc_s         = {XLEN{1'b0}};
        inst_s       = NOP_INST;
        if (!fifo_empty_s) begin
            valid_s = 1'b1;
            pc_s    = fifo_head_s.pc;
            inst_s  = fifo_head_s.inst;
        end
`ifdef FETCH_BYPASS_EN
        else if (resp_valid_s) begin
            valid_s = 1'b1;
            pc_s    = inflight_pc_r;
            inst_s  = bus.imem_rdata;
        end
`endif
        else begin
            valid_s = 1'b0;
            pc_s    = {XLEN{1'b0}};
            inst_s  = NOP_INST;
        end
    end

    // Pop/push and the request credit: count + inflight - pop must stay below depth.
    always_comb begin
        pop_s      = valid_s && !bus.stall;
        fifo_pop_s = pop_s && !fifo_empty_s;
`ifdef FETCH_BYPASS_EN
        // A bypassed response that IF/ID consumes right away is not buffered.
        push_s     = resp_valid_s && !(fifo_empty_s && !bus.stall);
`else
        push_s     = resp_valid_s;
`endif
        push_data_s.pc   = inflight_pc_r;
        push_data_s.inst = bus.imem_rdata;
        occupancy_s = OW'(fifo_count_s) + OW'(inflight_r) - OW'(pop_s);
        if (!reset && !bus.redirect && (occupancy_s < OW'(FIFO_DEPTH))) begin
            req_s = 1'b1;
        end else begin
            req_s = 1'b0;
        end
    end

    // Fetch PC and in-flight tracking; redirect wins over issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_r    <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= {XLEN{1'b0}};
        end else if (bus.redirect) begin
            fetch_pc_r    <= align_pc(bus.redirect_pc);
            inflight_r    <= 1'b0;
            inflight_pc_r <= inflight_pc_r;
        end else if (req_s) begin
            fetch_pc_r    <= fetch_pc_r + 64'd4;
            inflight_r    <= 1'b1;
            inflight_pc_r <= fetch_pc_r;
        end else begin
            fetch_pc_r    <= fetch_pc_r;
            inflight_r    <= 1'b0;
            inflight_pc_r <= inflight_pc_r;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.redirect),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (fifo_pop_s),
        .count     (fifo_count_s),
        .head      (fifo_head_s),
        .empty     (fifo_empty_s)
    );

    assign bus.imem_req  = req_s;
    assign bus.imem_addr = fetch_pc_r;
    assign bus.if_valid  = valid_s;
    assign bus.if_pc     = pc_s;
    assign bus.if_inst   = inst_s;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch: memory model plus a
// scoreboard of the program-order PC stream IF/ID is expected to capture.
module tb_instruction_fetch;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instruction_fetch_if bus ();
    instruction_fetch_if wbus ();

    instruction_fetch #(.RESET_PC(64'h0), .FIFO_DEPTH(2)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    instruction_fetch #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFF8), .FIFO_DEPTH(2)) dut_w (
        .clk(clk), .reset(reset), .bus(wbus)
    );

    int checks = 0;
    int failures = 0;
    int pops = 0;
    logic [63:0] exp_q [$];

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_stream(input logic [63:0] start, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(start + 64'(4 * i));
    endtask

    task automatic settle();
        #1;
    endtask

    // Scoreboard compare on every IF/ID capture, clock edge, then memory response.
    task automatic tick();
        logic        r_req;
        logic        w_req;
        logic [63:0] r_addr;
        logic [63:0] w_addr;
        logic [63:0] e;
        r_req  = bus.imem_req;
        r_addr = bus.imem_addr;
        w_req  = wbus.imem_req;
        w_addr = wbus.imem_addr;
        if (bus.if_valid === 1'b1 && bus.stall === 1'b0) begin
            pops++;
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL sb_unexpected: observed pc %h expected no capture", bus.if_pc);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_pc", bus.if_pc, e);
                chk("sb_inst", 64'(bus.if_inst), 64'(mem_word(e)));
            end
        end
        @(posedge clk);
        #1;
        bus.imem_rdata  = r_req ? mem_word(r_addr) : 32'hDEAD_BEEF;
        wbus.imem_rdata = w_req ? mem_word(w_addr) : 32'hDEAD_BEEF;
    endtask

    initial begin
        reset = 1'b1;
        bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 64'h0; bus.imem_rdata = 32'h0;
        wbus.stall = 1'b0; wbus.redirect = 1'b0; wbus.redirect_pc = 64'h0; wbus.imem_rdata = 32'h0;
        settle();
        tick(); tick();

        // Reset state
        settle();
        chk("rst_valid", 64'(bus.if_valid), 64'h0);
        chk("rst_inst", 64'(bus.if_inst), 64'h13);
        chk("rst_pc", bus.if_pc, 64'h0);
        chk("rst_req", 64'(bus.imem_req), 64'h0);

        // Reset release, free running
        reset = 1'b0;
        expect_stream(64'h0, 64);
        settle();
        chk("c0_req", 64'(bus.imem_req), 64'h1);
        chk("c0_addr", bus.imem_addr, 64'h0);
        chk("c0_valid", 64'(bus.if_valid), 64'h0);
        tick();
        settle();
        chk("c1_req", 64'(bus.imem_req), 64'h1);
        chk("c1_addr", bus.imem_addr, 64'h4);
        chk("c1_valid", 64'(bus.if_valid), 64'h0);
        tick();
        settle();
        chk("c2_valid", 64'(bus.if_valid), 64'h1);
        chk("c2_pc", bus.if_pc, 64'h0);
        chk("wrap_c2", wbus.if_pc, 64'hFFFF_FFFF_FFFF_FFF8);
        tick();
        settle();
        chk("wrap_c3", wbus.if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();

        // Five-cycle stall with head at 8
        bus.stall = 1'b1;
        settle();
        chk("stall_pc", bus.if_pc, 64'h8);
        chk("stall_req", 64'(bus.imem_req), 64'h0);
        chk("wrap_c4", wbus.if_pc, 64'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("stall_valid", 64'(bus.if_valid), 64'h1);
            chk("stall_pc", bus.if_pc, 64'h8);
            chk("stall_req", 64'(bus.imem_req), 64'h0);
            if (i == 0) chk("wrap_c5", wbus.if_pc, 64'h4);
            tick();
        end
        bus.stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("release_valid", 64'(bus.if_valid), 64'h1);
            chk("release_pc", bus.if_pc, 64'h8 + 64'(4 * i));
            tick();
        end

        // Fill the FIFO under stall, then redirect to an unaligned target
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("fill_pc", bus.if_pc, 64'h14);
            tick();
        end
        bus.redirect = 1'b1;
        bus.redirect_pc = 64'h1003;
        settle();
        chk("redir_req", 64'(bus.imem_req), 64'h0);
        tick();
        expect_stream(64'h1000, 32);
        bus.redirect = 1'b0;
        bus.stall = 1'b0;
        settle();
        chk("redir_r1_req", 64'(bus.imem_req), 64'h1);
        chk("redir_r1_addr", bus.imem_addr, 64'h1000);
        chk("redir_r1_valid", 64'(bus.if_valid), 64'h0);
        tick();
        settle();
        chk("redir_r2_valid", 64'(bus.if_valid), 64'h0);
        chk("redir_r2_addr", bus.imem_addr, 64'h1004);
        tick();
        settle();
        chk("redir_r3_valid", 64'(bus.if_valid), 64'h1);
        chk("redir_r3_pc", bus.if_pc, 64'h1000);
        tick();
        tick(); tick(); tick();

        // Redirect while a response is arriving: that response must vanish
        bus.redirect = 1'b1;
        bus.redirect_pc = 64'h2000;
        settle();
        chk("kill_req", 64'(bus.imem_req), 64'h0);
        tick();
        expect_stream(64'h2000, 32);
        bus.redirect = 1'b0;
        settle();
        chk("kill_r1_valid", 64'(bus.if_valid), 64'h0);
        chk("kill_r1_addr", bus.imem_addr, 64'h2000);
        tick();
        settle();
        chk("kill_r2_valid", 64'(bus.if_valid), 64'h0);
        tick();
        settle();
        chk("kill_r3_pc", bus.if_pc, 64'h2000);
        tick();
        tick(); tick();

        // Reset for one cycle with two entries buffered
        bus.stall = 1'b1;
        tick(); tick(); tick();
        settle();
        chk("pre_rst_valid", 64'(bus.if_valid), 64'h1);
        reset = 1'b1;
        settle();
        chk("mid_rst_req", 64'(bus.imem_req), 64'h0);
        tick();
        reset = 1'b0;
        bus.stall = 1'b0;
        expect_stream(64'h0, 32);
        settle();
        chk("post_rst_valid", 64'(bus.if_valid), 64'h0);
        chk("post_rst_inst", 64'(bus.if_inst), 64'h13);
        chk("post_rst_pc", bus.if_pc, 64'h0);
        chk("post_rst_addr", bus.imem_addr, 64'h0);
        tick(); tick();
        settle();
        chk("post_rst_c2_pc", bus.if_pc, 64'h0);
        tick(); tick();

        chk("capture_count", 64'(pops), 64'd15);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
